// File: rtl/sp_ram_bytewr_if.sv
// rtl/sp_ram_bytewr_if.sv - request/response bundle for the byte-writable single-port RAM
interface sp_ram_bytewr_if #(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 32,
    parameter int BYTEWIDTH = 8
);
    logic                             req_valid;
    logic                             req_ready;
    logic                             req_we;
    logic [ADDRWIDTH-1:0]             req_addr;
    logic [DATAWIDTH/BYTEWIDTH-1:0]   req_be;
    logic [DATAWIDTH-1:0]             req_wdata;
    logic                             rsp_valid;
    logic [DATAWIDTH-1:0]             rsp_rdata;
    logic                             busy;
    logic                             err_addr;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy, err_addr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy, err_addr
    );
endinterface

// File: rtl/sp_ram_bytewr.sv
// rtl/sp_ram_bytewr.sv - single-port RAM with byte write enables, zero-fill after reset
module sp_ram_bytewr #(
    parameter int ADDRWIDTH      = 4,
    parameter int DATAWIDTH      = 32,
    parameter int BYTEWIDTH      = 8,
    parameter int SIZE           = 16,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sp_ram_bytewr_if.slave  bus
);
    localparam int NBYTES = DATAWIDTH / BYTEWIDTH;
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(SIZE - 1);

    if (DATAWIDTH % BYTEWIDTH != 0) begin : g_bad_width
        $error("sp_ram_bytewr: DATAWIDTH must be a multiple of BYTEWIDTH");
    end
    if (SIZE < 1 || SIZE > (2 ** ADDRWIDTH)) begin : g_bad_size
        $error("sp_ram_bytewr: SIZE must be in 1..2**ADDRWIDTH");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_oreg
        $error("sp_ram_bytewr: OUT_REG must be 0 or 1");
    end

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                   ready_q, ready_d;
    logic                   rd_v1_q, rd_v1_d;
    logic                   err1_q, err1_d;
    logic [DATAWIDTH-1:0]   rdata1_q, rdata1_d;

    logic                   accept;
    logic                   in_range;
    logic                   busy_o;
    logic                   mem_we;
    logic [ADDRWIDTH-1:0]   mem_waddr;
    logic [NBYTES-1:0]      mem_be;
    logic [DATAWIDTH-1:0]   mem_wdata;

    logic [DATAWIDTH-1:0]   mem [SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDRWIDTH'(1);
            end
        end
        // ready is registered so it reads 0 during reset even when the fill is skipped
        ready_d = (state_d == ST_RUN);
    end

    always_comb begin
        busy_o    = (state_q == ST_CLEAR);
        mem_we    = 1'b0;
        mem_waddr = bus.req_addr;
        mem_be    = bus.req_be;
        mem_wdata = bus.req_wdata;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_be    = '1;
            mem_wdata = '0;
        end else begin
            mem_we    = accept & bus.req_we & in_range;
        end
    end

    assign accept   = bus.req_valid & ready_q;
    assign in_range = ({1'b0, bus.req_addr} < (ADDRWIDTH + 1)'(SIZE));

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_waddr][i*BYTEWIDTH +: BYTEWIDTH] <= mem_wdata[i*BYTEWIDTH +: BYTEWIDTH];
                end
            end
        end
    end

    // out-of-range reads return zero; err follows the slot a response would use, writes included
    always_comb begin
        rd_v1_d  = accept & ~bus.req_we;
        err1_d   = accept & ~in_range;
        rdata1_d = rdata1_q;
        if (rd_v1_d) begin
            rdata1_d = in_range ? mem[bus.req_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q  <= 1'b0;
            err1_q   <= 1'b0;
            rdata1_q <= '0;
        end else begin
            rd_v1_q  <= rd_v1_d;
            err1_q   <= err1_d;
            rdata1_q <= rdata1_d;
        end
    end

    if (OUT_REG == 1) begin : g_oreg
        logic                 rd_v2_q, err2_q;
        logic [DATAWIDTH-1:0] rdata2_q, rdata2_d;

        always_comb begin
            rdata2_d = rd_v1_q ? rdata1_q : rdata2_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_v2_q  <= 1'b0;
                err2_q   <= 1'b0;
                rdata2_q <= '0;
            end else begin
                rd_v2_q  <= rd_v1_q;
                err2_q   <= err1_q;
                rdata2_q <= rdata2_d;
            end
        end

        assign bus.rsp_valid = rd_v2_q;
        assign bus.err_addr  = err2_q;
        assign bus.rsp_rdata = rdata2_q;
    end else begin : g_noreg
        assign bus.rsp_valid = rd_v1_q;
        assign bus.err_addr  = err1_q;
        assign bus.rsp_rdata = rdata1_q;
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_o;
endmodule
